// File: rtl/button_click_decoder.sv
// rtl/button_click_decoder.sv - groups press pulses arriving within a gap window into one click-count event
module button_click_decoder #(
  parameter int GAP_CYCLES = 16,
  parameter int MAX_CLICKS = 3,
  localparam int CW = $clog2(MAX_CLICKS + 1)
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          press_in,
  output logic          click_valid,
  input  logic          click_ready,
  output logic [CW-1:0] click_count,
  output logic          busy,
  output logic          overflow
);

  localparam int TW = $clog2(GAP_CYCLES);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            press_d_q;
  logic            valid_q, valid_d;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic            press_evt;
  logic            emit;

  assign press_evt = press_in & ~press_d_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_evt) begin
          state_d = COUNT;
          cnt_d   = CW'(1);
          timer_d = '0;
        end
      end
      COUNT: begin
        // A press in the expiry cycle extends the group rather than closing it.
        if (press_evt) begin
          timer_d = '0;
          if (cnt_q != CW'(MAX_CLICKS)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (timer_q == TW'(GAP_CYCLES - 1)) begin
          emit    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    busy_d  = (state_d == COUNT);
    if (valid_q && click_ready) begin
      valid_d = 1'b0;
    end
    // Slot is free when empty or being accepted this cycle.
    if (emit) begin
      if (!valid_q || click_ready) begin
        valid_d = 1'b1;
        count_d = cnt_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      press_d_q <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      press_d_q <= press_in;
      valid_q   <= valid_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign click_valid = valid_q;
  assign click_count = count_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/button_click_decoder.md
Name: button_click_decoder

Overview:
- Sits directly downstream of button_detect and consumes its one-cycle press pulse (button_out).
- Groups presses that arrive within a programmable gap window into one click event: single, double, triple, and so on.
- Presents each event as a click count on a valid/ready output to the mode/control logic.

Parameters:
GAP_CYCLES, 16, clk_sys cycles of silence after the last press that close a click group; must be >= 2
MAX_CLICKS, 3, saturation value of the click count; must be >= 1
CW, $clog2(MAX_CLICKS+1), derived width of click_count; not overridden

Ports:
clk_sys  input  1  system clock; all logic is on the rising edge
rst  input  1  asynchronous, active-high reset
press_in  input  1  press event from button_detect.button_out; counted on its 0->1 edge
click_valid  output  1  a click event is held on click_count
click_ready  input  1  consumer accepts the event
click_count  output  CW  number of presses in the group, 1..MAX_CLICKS
busy  output  1  high while a group is open (state COUNT)
overflow  output  1  sticky; a completed group was dropped because the output was occupied

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE, timer=0, cnt=0, press_d=0.
  - click_valid=0, click_count=0, busy=0, overflow=0.
  - Takes effect immediately, including mid-group and mid-handshake; the pending event and open group are discarded.
- Edge extraction:
  - press_d registers press_in.
  - press_evt = press_in & ~press_d.
  - A press_in held high for N cycles counts as exactly one press.
- State IDLE:
  - On press_evt: go to COUNT, cnt<=1, timer<=0.
- State COUNT:
  - On press_evt:
    - timer<=0.
    - cnt<=cnt+1, saturating at MAX_CLICKS; extra presses are absorbed and do not restart anything else.
  - Without press_evt:
    - If timer==GAP_CYCLES-1, the group closes: emit, then go to IDLE with cnt<=0, timer<=0.
    - Otherwise timer<=timer+1.
  - If press_evt and the expiry condition occur in the same cycle, the press wins: the group extends and does not close.
- busy = (state==COUNT), registered.
- Latency:
  - The last press edge is sampled at cycle t.
  - The group closes at the edge ending cycle t+GAP_CYCLES.
  - click_valid is high from cycle t+GAP_CYCLES+1.
- Emit:
  - If the output slot is free, load click_count<=cnt and set click_valid<=1.
  - The slot is free when click_valid==0, or when click_valid & click_ready in the same cycle (back-to-back accept and load is allowed).
  - If the slot is occupied and not being accepted, drop the new group and set overflow<=1.
  - overflow is cleared only by rst.
- Output handshake:
  - click_valid stays high and click_count stays stable until click_valid & click_ready at a clock edge.
  - On that edge click_valid<=0, unless a new emit loads in the same cycle.
  - click_count keeps its last value while click_valid=0.
  - click_ready is ignored while click_valid=0.
- A press_evt arriving in IDLE in the cycle immediately after a group closes starts a new group normally.
- The timer is sized $clog2(GAP_CYCLES) bits and never counts past GAP_CYCLES-1, so it never wraps.

Test Plan:
1. Reset defaults: rst=1 for 2 cycles, then 0 → all outputs 0, busy=0; a press_in pulse during rst is ignored.
2. Single click, GAP_CYCLES=16, click_ready tied 1:
   - press_in high 1 cycle at t=10 → busy=1 from t=11.
   - click_valid=1 with click_count=1 at t=27 only, for one cycle.
   - busy=0 from t=27.
3. Double/triple and held press:
   - Press edges at t=10, t=20 (press_in held 5 cycles), t=30 → one event, click_count=3, valid at t=47.
   - A 4th edge at t=40 still gives click_count=3 (saturation), valid at t=57.
4. Boundary:
   - Edges at t=10 and t=26 (the expiry cycle) → group extends, click_count=2, valid at t=43.
   - Edges at t=10 and t=27 → click_count=1 valid at t=27, then a new group with click_count=1 valid at t=44.
5. Backpressure: click_ready=0; complete two separate single-click groups.
   - First event is held with click_count=1.
   - Second group is dropped and overflow=1.
   - Raise click_ready: click_valid drops the next cycle; overflow stays 1.
6. Reset mid-group: edge at t=10, rst pulse at t=15 → busy=0 immediately, no click_valid ever issued for that group.
